seq_div16: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/div_sub_stage.sv | 21 ++
 rtl/seq_div16.sv | 174 +++++++++++++++++
 tb/tb_seq_div16.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, datapath width,
// and the divide-by-zero quotient constant.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [ALU_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: (WIDTH+1)-bit trial subtract and
// restore mux producing the next partial remainder and quotient bit.
module div_sub_stage #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   shifted,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // shifted < 2*divisor, so the difference always fits in WIDTH+1 bits
    always_comb begin
        trial    = shifted - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div16.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN to add the signed_op port and sign handling.
module seq_div16
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t state, state_n;

    logic [WIDTH-1:0] rem_r, rem_n;
    logic [WIDTH-1:0] quo_r, quo_n;
    logic [WIDTH-1:0] dvs_r, dvs_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;

    logic [WIDTH-1:0] quotient_n;
    logic [WIDTH-1:0] remainder_n;
    logic             div_zero_n;
    logic             busy_n;
    logic             done_n;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic             q_bit;

`ifdef SEQ_DIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_q_r, neg_q_n;
    logic neg_r_r, neg_r_n;

    always_comb begin
        a_neg = signed_op & dividend[WIDTH-1];
        b_neg = signed_op & divisor[WIDTH-1];
        a_mag = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag = b_neg ? (~divisor + 1'b1) : divisor;
        q_fin = neg_q_r ? (~quo_step + 1'b1) : quo_step;
        r_fin = neg_r_r ? (~rem_step + 1'b1) : rem_step;
    end
`else
    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
        q_fin = quo_step;
        r_fin = rem_step;
    end
`endif

    div_sub_stage #(
        .WIDTH(WIDTH)
    ) u_sub (
        .shifted  ({rem_r, quo_r[WIDTH-1]}),
        .divisor  (dvs_r),
        .rem_next (rem_step),
        .q_bit    (q_bit)
    );

    assign quo_step = {quo_r[WIDTH-2:0], q_bit};

    always_comb begin
        state_n     = state;
        rem_n       = rem_r;
        quo_n       = quo_r;
        dvs_n       = dvs_r;
        cnt_n       = cnt_r;
        quotient_n  = quotient;
        remainder_n = remainder;
        div_zero_n  = div_zero;
`ifdef SEQ_DIV_SIGNED_EN
        neg_q_n     = neg_q_r;
        neg_r_n     = neg_r_r;
`endif

        unique case (state)
            IDLE: begin
                if (start) begin
                    dvs_n      = b_mag;
                    div_zero_n = 1'b0;
                    if (divisor == '0) begin
                        state_n     = DONE;
                        quotient_n  = WIDTH'(DIV0_QUOTIENT);
                        remainder_n = dividend;
                        div_zero_n  = 1'b1;
                    end else begin
                        state_n = CALC;
                        rem_n   = '0;
                        quo_n   = a_mag;
                        cnt_n   = CNT_W'(WIDTH - 1);
`ifdef SEQ_DIV_SIGNED_EN
                        neg_q_n = a_neg ^ b_neg;
                        neg_r_n = a_neg;
`endif
                    end
                end
            end
            CALC: begin
                rem_n = rem_step;
                quo_n = quo_step;
                // leave the counter at zero on the last step
                if (cnt_r == '0) begin
                    state_n     = DONE;
                    quotient_n  = q_fin;
                    remainder_n = r_fin;
                end else begin
                    cnt_n = cnt_r - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            cnt_r     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            rem_r     <= rem_n;
            quo_r     <= quo_n;
            dvs_r     <= dvs_n;
            cnt_r     <= cnt_n;
            quotient  <= quotient_n;
            remainder <= remainder_n;
            div_zero  <= div_zero_n;
            busy      <= busy_n;
            done      <= done_n;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_r   <= neg_q_n;
            neg_r_r   <= neg_r_n;
`endif
        end
    end

endmodule

// File: tb/tb_seq_div16.sv
// Scoreboard bench for seq_div16: results, latency, busy span,
// ignored starts, back-to-back issue and asynchronous abort.
module tb_seq_div16;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
`ifdef SEQ_DIV_SIGNED_EN
    logic        signed_op;
`endif
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;

    res_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    seq_div16 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef SEQ_DIV_SIGNED_EN
        .signed_op (signed_op),
`endif
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] a,
                                   input logic [15:0] b,
                                   input logic sg);
        res_t m;
        int   sa;
        int   sbv;
        int   qq;
        int   rr;
        m.dz = 1'b0;
        if (b == 16'd0) begin
            m.q  = 16'hFFFF;
            m.r  = a;
            m.dz = 1'b1;
        end else if (sg) begin
            sa  = int'($signed(a));
            sbv = int'($signed(b));
            qq  = sa / sbv;
            rr  = sa % sbv;
            m.q = qq[15:0];
            m.r = rr[15:0];
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
        return m;
    endfunction

    // drive start so it is sampled at the next rising edge (E0)
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic sg, input logic push);
        dividend = a;
        divisor  = b;
`ifdef SEQ_DIV_SIGNED_EN
        signed_op = sg;
`endif
        start = 1'b1;
        if (push) exp_q.push_back(model(a, b, sg));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_edge,
                             input int exp_busy);
        int n  = 0;
        int nb = 0;
        bit seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                seen = 1'b1;
                n = i;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_lat"}, 32'(n - 1), 32'(exp_edge));
            chk({tag, "_busy"}, 32'(nb), 32'(exp_busy));
            @(negedge clk);
            chk({tag, "_idle"}, 32'({busy, done}), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        res_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_q", 32'(quotient), 32'(e.q));
                chk("sb_r", 32'(remainder), 32'(e.r));
                chk("sb_dz", 32'(div_zero), 32'(e.dz));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no summary after time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        logic [15:0] ra;
        logic [15:0] rb;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef SEQ_DIV_SIGNED_EN
        signed_op = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(16'd100, 16'd7, 1'b0, 1'b1);
        wait_done("d100_7", 16, 17);
        send(16'hFFFF, 16'd1, 1'b0, 1'b1);
        wait_done("dffff_1", 16, 17);
        send(16'd3, 16'h0010, 1'b0, 1'b1);
        wait_done("d3_16", 16, 17);
        send(16'd5, 16'd0, 1'b0, 1'b1);
        wait_done("d5_0", 0, 1);

        // start at E8 must be ignored
        send(16'd100, 16'd7, 1'b0, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ign_e8", 8, 9);

        // start held from the done cycle: dropped in DONE, taken from IDLE
        send(16'd200, 16'd9, 1'b0, 1'b1);
        repeat (16) @(posedge clk);
        #1;
        chk("b2b_done", 32'(done), 32'd1);
        dividend = 16'd1000;
        divisor  = 16'd33;
        start    = 1'b1;
        exp_q.push_back(model(16'd1000, 16'd33, 1'b0));
        @(posedge clk);
        #1;
        chk("b2b_e17_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_e18_acc", 32'(busy), 32'd1);
        wait_done("b2b_2nd", 16, 17);

        // asynchronous abort at E5
        send(16'd100, 16'd7, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_dz", 32'(div_zero), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_nodone", 32'(ndone), 32'd0);
        send(16'd9, 16'd4, 1'b0, 1'b1);
        wait_done("d9_4", 16, 17);

        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = (i % 3 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom);
            if (i == 5) rb = 16'd0;
            send(ra, rb, 1'b0, 1'b1);
            wait_done("rand", (rb == 16'd0) ? 0 : 16, (rb == 16'd0) ? 1 : 17);
        end

`ifdef SEQ_DIV_SIGNED_EN
        send(16'hFFF9, 16'd2, 1'b1, 1'b1);
        wait_done("s_m7_2", 16, 17);
        send(16'd7, 16'hFFFE, 1'b1, 1'b1);
        wait_done("s_7_m2", 16, 17);
        send(16'h8000, 16'hFFFF, 1'b1, 1'b1);
        wait_done("s_min_m1", 16, 17);
        send(16'hFFF9, 16'd2, 1'b0, 1'b1);
        wait_done("s_off", 16, 17);
        send(16'hFFF9, 16'd0, 1'b1, 1'b1);
        wait_done("s_dz", 0, 1);
`endif

        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
